// File: rtl/free_list_pkg.sv
// Shared sizing and tag types for the physical register free list.
package free_list_pkg;
    localparam int N            = 3;
    localparam int ARCH_REG_SZ  = 32;
    localparam int PHYS_REG_SZ  = 64;
    localparam int FREE_LIST_SZ = PHYS_REG_SZ - ARCH_REG_SZ;
    localparam int PHYS_TAG_W   = $clog2(PHYS_REG_SZ);

    typedef logic [PHYS_TAG_W-1:0] phys_tag_t;
endpackage

// File: rtl/free_list.sv
// Circular free-tag FIFO: dispatch pops from head, retire pushes at tail,
// mispredict rewinds head to the architectural head.
module free_list
    import free_list_pkg::*;
#(
    parameter int ALLOC_WIDTH = N,
    parameter int FREE_WIDTH  = N,
    parameter int FL_SZ       = FREE_LIST_SZ,
    localparam int ACW        = $clog2(ALLOC_WIDTH + 1),
    localparam int CNT_W      = $clog2(FL_SZ + 1)
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [ACW-1:0]                   alloc_count,
    output phys_tag_t [ALLOC_WIDTH-1:0]      alloc_tags,
    output logic [CNT_W-1:0]                 free_count,
    output logic                             alloc_reject,
    input  logic [FREE_WIDTH-1:0]            free_valid,
    input  phys_tag_t [FREE_WIDTH-1:0]       free_tags,
    input  logic                             mispredict
);
    localparam int IDX_W = $clog2(FL_SZ);
    localparam int FCW   = $clog2(FREE_WIDTH + 1);

    typedef logic [IDX_W-1:0] fl_idx_t;
    typedef logic [CNT_W-1:0] fl_cnt_t;

    // Operands stay below FL_SZ, so one conditional subtract wraps any size.
    function automatic fl_idx_t wrap_add(fl_idx_t idx, int n);
        int s;
        s = int'(idx) + n;
        if (s >= FL_SZ) s = s - FL_SZ;
        return fl_idx_t'(s);
    endfunction

    phys_tag_t fl_buf_q [FL_SZ];
    phys_tag_t fl_buf_d [FL_SZ];
    fl_idx_t   head_q, head_d, arch_head_q, arch_head_d, tail_q, tail_d;
    fl_cnt_t   free_cnt_q, free_cnt_d, spec_cnt_q, spec_cnt_d;
    fl_cnt_t   n_alloc;
    logic [FCW-1:0] n_free;

    always_comb begin
        fl_buf_d = fl_buf_q;
        n_free   = '0;
        // Compact valid retire slots into consecutive tail positions.
        for (int j = 0; j < FREE_WIDTH; j++) begin
            if (free_valid[j]) begin
                fl_buf_d[wrap_add(tail_q, int'(n_free))] = free_tags[j];
                n_free = n_free + FCW'(1);
            end
        end

        alloc_reject = !mispredict && (fl_cnt_t'(alloc_count) > free_cnt_q);
        n_alloc      = (mispredict || alloc_reject) ? '0 : fl_cnt_t'(alloc_count);

        tail_d      = wrap_add(tail_q, int'(n_free));
        arch_head_d = wrap_add(arch_head_q, int'(n_free));

        if (mispredict) begin
            head_d     = arch_head_d;
            free_cnt_d = free_cnt_q + spec_cnt_q;
            spec_cnt_d = '0;
        end else begin
            head_d     = wrap_add(head_q, int'(n_alloc));
            free_cnt_d = free_cnt_q - n_alloc + fl_cnt_t'(n_free);
            spec_cnt_d = spec_cnt_q + n_alloc - fl_cnt_t'(n_free);
        end
    end

    always_comb begin
        alloc_tags = '0;
        for (int i = 0; i < ALLOC_WIDTH; i++)
            alloc_tags[i] = fl_buf_q[wrap_add(head_q, i)];
        free_count = free_cnt_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < FL_SZ; i++)
                fl_buf_q[i] <= phys_tag_t'(ARCH_REG_SZ + i);
            head_q      <= '0;
            arch_head_q <= '0;
            tail_q      <= '0;
            free_cnt_q  <= fl_cnt_t'(FL_SZ);
            spec_cnt_q  <= '0;
        end else begin
            fl_buf_q    <= fl_buf_d;
            head_q      <= head_d;
            arch_head_q <= arch_head_d;
            tail_q      <= tail_d;
            free_cnt_q  <= free_cnt_d;
            spec_cnt_q  <= spec_cnt_d;
        end
    end

    always @(posedge clock) begin
        if (!reset) begin
            assert (int'(free_cnt_q) + int'(spec_cnt_q) == FL_SZ);
            assert (int'(free_cnt_q) <= FL_SZ);
            assert (!(alloc_reject && alloc_count == '0));
            assert (int'(n_free) <= int'(spec_cnt_q));
            for (int i = 1; i < FL_SZ; i++)
                for (int j = 0; j < i; j++)
                    if (i < int'(free_cnt_q))
                        assert (fl_buf_q[wrap_add(head_q, i)] != fl_buf_q[wrap_add(head_q, j)]);
        end
    end
endmodule

// File: tb/tb_free_list.sv
// Directed vector table plus a wrap-around alloc/free stream for free_list.
module tb_free_list;
    import free_list_pkg::*;

    logic                 clock, reset, mispredict, alloc_reject;
    logic [1:0]           alloc_count;
    phys_tag_t [2:0]      alloc_tags;
    logic [5:0]           free_count;
    logic [2:0]           free_valid;
    phys_tag_t [2:0]      free_tags;

    int checks = 0;
    int errors = 0;

    free_list dut (
        .clock(clock), .reset(reset), .alloc_count(alloc_count), .alloc_tags(alloc_tags),
        .free_count(free_count), .alloc_reject(alloc_reject), .free_valid(free_valid),
        .free_tags(free_tags), .mispredict(mispredict)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       rst;
        logic [1:0] ac;
        logic [2:0] fv;
        logic [5:0] ft0, ft1, ft2;
        logic       mp;
        logic       erej;
        logic [5:0] e0, e1, e2;
        logic [5:0] efc;
    } vec_t;

    vec_t vecs[$];

    // Tags at or beyond the expected free count are don't-care.
    function automatic vec_t mk(logic rst, int ac, logic [2:0] fv, int f0, int f1, int f2,
                                logic mp, logic erej, int e0, int e1, int e2, int efc);
        vec_t v;
        v.rst = rst; v.ac = 2'(ac); v.fv = fv;
        v.ft0 = 6'(f0); v.ft1 = 6'(f1); v.ft2 = 6'(f2);
        v.mp = mp; v.erej = erej;
        v.e0 = 6'(e0); v.e1 = 6'(e1); v.e2 = 6'(e2); v.efc = 6'(efc);
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_tags(string name, logic [5:0] efc, logic [5:0] e0, logic [5:0] e1, logic [5:0] e2);
        logic [5:0] exp_t [3];
        exp_t[0] = e0; exp_t[1] = e1; exp_t[2] = e2;
        check({name, " free_count"}, 32'(free_count), 32'(efc));
        for (int i = 0; i < 3; i++)
            if (i < int'(efc))
                check($sformatf("%s tag%0d", name, i), 32'(alloc_tags[i]), 32'(exp_t[i]));
    endtask

    initial begin
        phys_tag_t q[$];
        phys_tag_t prev, nxt;
        int s;

        reset = 1'b1; alloc_count = '0; free_valid = '0; free_tags = '0; mispredict = 1'b0;

        // reset and first pop
        vecs.push_back(mk(1, 0, 3'b000, 0, 0, 0, 0, 0, 32, 33, 34, 32));
        vecs.push_back(mk(0, 3, 3'b000, 0, 0, 0, 0, 0, 35, 36, 37, 29));
        // drain down to 2 left
        for (int k = 1; k <= 9; k++)
            vecs.push_back(mk(0, 3, 3'b000, 0, 0, 0, 0, 0, 35+3*k, 36+3*k, 37+3*k, 29-3*k));
        vecs.push_back(mk(0, 3, 3'b000, 0, 0, 0, 0, 1, 62, 63, 0, 2));
        vecs.push_back(mk(0, 2, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // free while empty: alloc sees registered zero, no bypass
        vecs.push_back(mk(0, 1, 3'b001, 0, 0, 0, 0, 1, 0, 0, 0, 1));
        // sparse free slots compacted in order, alloc 1 in same cycle
        vecs.push_back(mk(0, 1, 3'b101, 40, 17, 45, 0, 0, 40, 45, 0, 2));
        vecs.push_back(mk(0, 1, 3'b000, 0, 0, 0, 0, 0, 45, 0, 0, 1));
        vecs.push_back(mk(0, 1, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // allocate 10, retire 4, mispredict
        vecs.push_back(mk(1, 0, 3'b000, 0, 0, 0, 0, 0, 32, 33, 34, 32));
        vecs.push_back(mk(0, 3, 3'b000, 0, 0, 0, 0, 0, 35, 36, 37, 29));
        vecs.push_back(mk(0, 3, 3'b000, 0, 0, 0, 0, 0, 38, 39, 40, 26));
        vecs.push_back(mk(0, 3, 3'b000, 0, 0, 0, 0, 0, 41, 42, 43, 23));
        vecs.push_back(mk(0, 1, 3'b000, 0, 0, 0, 0, 0, 42, 43, 44, 22));
        vecs.push_back(mk(0, 0, 3'b111, 0, 1, 2, 0, 0, 42, 43, 44, 25));
        vecs.push_back(mk(0, 0, 3'b010, 9, 3, 9, 0, 0, 42, 43, 44, 26));
        vecs.push_back(mk(0, 3, 3'b000, 0, 0, 0, 1, 0, 36, 37, 38, 32));
        // mispredict with a same-cycle free rewinds to the updated arch head
        vecs.push_back(mk(0, 3, 3'b000, 0, 0, 0, 0, 0, 39, 40, 41, 29));
        vecs.push_back(mk(0, 2, 3'b001, 5, 0, 0, 1, 0, 37, 38, 39, 32));
        // reset mid-stream with pending alloc and free
        vecs.push_back(mk(0, 3, 3'b000, 0, 0, 0, 0, 0, 40, 41, 42, 29));
        vecs.push_back(mk(1, 3, 3'b111, 7, 8, 9, 0, 0, 32, 33, 34, 32));

        foreach (vecs[vi]) begin
            @(negedge clock);
            reset = vecs[vi].rst; alloc_count = vecs[vi].ac; free_valid = vecs[vi].fv;
            free_tags[0] = vecs[vi].ft0; free_tags[1] = vecs[vi].ft1; free_tags[2] = vecs[vi].ft2;
            mispredict = vecs[vi].mp;
            #1;
            if (!vecs[vi].rst)
                check($sformatf("v%0d reject", vi), 32'(alloc_reject), 32'(vecs[vi].erej));
            @(posedge clock); #1;
            check_tags($sformatf("v%0d", vi), vecs[vi].efc, vecs[vi].e0, vecs[vi].e1, vecs[vi].e2);
        end

        // wrap stream: 1 in flight, each cycle alloc one and retire the previous one
        @(negedge clock);
        reset = 1'b0; mispredict = 1'b0; free_valid = '0; alloc_count = 2'd1;
        for (int i = 0; i < 32; i++) q.push_back(phys_tag_t'(32 + i));
        prev = q.pop_front();
        @(posedge clock); #1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            s = c % 3;
            free_tags = {phys_tag_t'($urandom), phys_tag_t'($urandom), phys_tag_t'($urandom)};
            free_tags[s] = prev;
            free_valid = 3'(1 << s);
            nxt = q.pop_front();
            q.push_back(prev);
            prev = nxt;
            #1;
            check($sformatf("wrap%0d reject", c), 32'(alloc_reject), 32'd0);
            @(posedge clock); #1;
            check_tags($sformatf("wrap%0d", c), 6'd31, q[0], q[1], q[2]);
        end

        @(negedge clock);
        alloc_count = '0; free_valid = '0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
